// File: rtl/sdram_stream_reader.sv
// sdram_stream_reader: plays back ping-pong halves of SDRAM into a show-ahead
// output FIFO, one outstanding read at a time, and steers the loader's
// half-select so the reader and the loader never share a half.
//
// state | meaning
// IDLE  | after reset, waiting for the loader's first half
// REQ   | issuing a read when enabled and the FIFO has room
// WAIT  | one read in flight, waiting for its data strobe
// HOLD  | finished a half, waiting for the loader to finish the other one
module sdram_stream_reader #(
  parameter int HALF_BITS  = 23,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        fill_done,
  output logic        fill_half,
  output logic        ram_re,
  output logic [24:0] ram_address,
  input  logic        ram_op_begun,
  input  logic [15:0] ram_rdata,
  input  logic        ram_rdata_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        half_done,
  output logic        underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t               state;
  logic [HALF_BITS:0]   rd_ptr;
  logic                 boundary;
  logic                 armed;
  logic [15:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        rd_idx;
  logic [AW:0]          count;

  logic push;
  logic pop;
  logic fire;
  logic last_word;

  assign push      = (state == WAIT) && ram_rdata_valid;
  assign pop       = out_ready && (count != '0);
  assign fire      = armed && fill_done;
  assign last_word = &rd_ptr[HALF_BITS-1:0];

  assign ram_re      = (state == REQ) && enable && (count < FULL_CNT);
  assign ram_address = {{(24 - HALF_BITS){1'b0}}, rd_ptr};
  assign out_data    = mem[rd_idx];
  assign out_valid   = (count != '0);

  // Sequencer: request issue, pointer advance, half hand-over with the loader.
  // fill_done must be seen low after each hand-over so a level left over from
  // the previous half cannot release the next one.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      boundary  <= 1'b0;
      armed     <= 1'b1;
      fill_half <= 1'b0;
      half_done <= 1'b0;
    end else begin
      half_done <= 1'b0;
      if (!fill_done) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (fire) begin
            fill_half <= ~fill_half;
            armed     <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (ram_re && ram_op_begun) begin
            rd_ptr <= rd_ptr + (HALF_BITS + 1)'(1);
            state  <= WAIT;
            if (last_word) begin
              half_done <= 1'b1;
              boundary  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (ram_rdata_valid) state <= boundary ? HOLD : REQ;
        end
        HOLD: begin
          if (fire) begin
            fill_half <= ~fill_half;
            armed     <= 1'b0;
            boundary  <= 1'b0;
            state     <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Underrun flag: consumer asked for data while the stream is supposed to be live.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) underrun <= 1'b0;
    else          underrun <= out_ready && (count == '0) && ((state == REQ) || (state == WAIT));
  end

  // Show-ahead FIFO; storage is cleared so the head word reads 0 out of reset.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= ram_rdata;
        wr_idx      <= wr_idx + AW'(1);
      end
      if (pop) rd_idx <= rd_idx + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Bench for sdram_stream_reader: 16-word halves, 4-deep FIFO, RAM model
// returning addr ^ 16'hA500 three cycles after acceptance.
module tb_sdram_stream_reader;

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        fill_done;
  logic        fill_half;
  logic        ram_re;
  logic [24:0] ram_address;
  logic        ram_op_begun;
  logic [15:0] ram_rdata;
  logic        ram_rdata_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        half_done;
  logic        underrun;

  sdram_stream_reader #(.HALF_BITS(4), .FIFO_DEPTH(4)) dut (
    .clk50          (clk50),
    .reset_n        (reset_n),
    .enable         (enable),
    .fill_done      (fill_done),
    .fill_half      (fill_half),
    .ram_re         (ram_re),
    .ram_address    (ram_address),
    .ram_op_begun   (ram_op_begun),
    .ram_rdata      (ram_rdata),
    .ram_rdata_valid(ram_rdata_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .half_done      (half_done),
    .underrun       (underrun)
  );

  always #10 clk50 = ~clk50;

  assign ram_op_begun = ram_re;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb [$];
  int          acc_cnt = 0;
  int          pops    = 0;
  int          hd_cnt  = 0;
  int          ur_cnt  = 0;
  int          cnt     = 0;
  logic [15:0] pend_addr;
  logic [15:0] last_addr;
  logic        model_on = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM model: samples the request just before the active edge, returns data
  // three edges after acceptance.
  initial begin
    ram_rdata       = '0;
    ram_rdata_valid = 1'b0;
    forever begin
      @(negedge clk50);
      #3;
      if (model_on) begin
        ram_rdata_valid = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            ram_rdata_valid = 1'b1;
            ram_rdata       = pend_addr ^ 16'hA500;
          end
        end
        if (ram_re && ram_op_begun) begin
          pend_addr = ram_address[15:0];
          last_addr = ram_address[15:0];
          cnt       = 3;
          acc_cnt++;
          sb.push_back(ram_address[15:0] ^ 16'hA500);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Consumer side: compare each accepted word with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk50);
      #3;
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_word", out_data, 32'hFFFF_FFFF);
        else chk("out_data", out_data, sb.pop_front());
        pops++;
      end
      if (half_done) begin
        hd_cnt++;
        chk("half_done_addr", ram_address[3:0], 4'h0);
      end
      if (underrun) ur_cnt++;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk50);
  endtask

  initial begin
    int acc0;
    int ur0;
    logic [24:0] nxt;
    reset_n   = 1'b0;
    enable    = 1'b1;
    fill_done = 1'b0;
    out_ready = 1'b1;
    cycles(3);
    #3;
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_fill_half", fill_half, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_half_done", half_done, 0);
    chk("rst_underrun", underrun, 0);
    @(negedge clk50);
    reset_n = 1'b1;
    cycles(3);
    chk("idle_no_req", ram_re, 0);
    chk("idle_no_underrun", ur_cnt, 0);

    // First half
    fill_done = 1'b1;
    for (int i = 0; i < 20 && fill_half !== 1'b1; i++) @(negedge clk50);
    chk("p1_fill_half", fill_half, 1);
    for (int i = 0; i < 400 && pops < 16; i++) @(negedge clk50);
    chk("p1_pops", pops, 16);
    cycles(10);
    chk("p1_half_done_cnt", hd_cnt, 1);
    chk("p1_underrun_seen", ur_cnt > 0, 1);
    chk("p1_hold_no_req", ram_re, 0);
    ur0 = ur_cnt;
    cycles(20);
    chk("p1_hold_acc", acc_cnt, 16);
    chk("p1_hold_fill_half", fill_half, 1);
    chk("p1_hold_no_underrun", ur_cnt, ur0);

    // Second half
    fill_done = 1'b0;
    @(negedge clk50);
    fill_done = 1'b1;
    for (int i = 0; i < 20 && fill_half !== 1'b0; i++) @(negedge clk50);
    chk("p2_fill_half", fill_half, 0);
    for (int i = 0; i < 400 && pops < 32; i++) @(negedge clk50);
    chk("p2_pops", pops, 32);
    cycles(10);
    chk("p2_half_done_cnt", hd_cnt, 2);
    chk("p2_wrap_addr", ram_address, 0);
    chk("p2_hold_no_req", ram_re, 0);

    // Backpressure: FIFO fills to 4 then requests stop
    out_ready = 1'b0;
    fill_done = 1'b0;
    @(negedge clk50);
    fill_done = 1'b1;
    for (int i = 0; i < 20 && fill_half !== 1'b1; i++) @(negedge clk50);
    chk("p3_fill_half", fill_half, 1);
    cycles(40);
    chk("p3_acc", acc_cnt, 36);
    chk("p3_no_req_full", ram_re, 0);
    chk("p3_out_valid", out_valid, 1);
    chk("p3_head", out_data, 16'hA500);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && pops < 36; i++) @(negedge clk50);
    chk("p3_drained", pops >= 36, 1);

    // Disable while a read is in flight
    for (int i = 0; i < 50 && cnt == 0; i++) @(negedge clk50);
    chk("p4_in_flight", cnt > 0, 1);
    enable = 1'b0;
    acc0 = acc_cnt;
    cycles(20);
    chk("p4_no_new_acc", acc_cnt, acc0);
    chk("p4_no_req", ram_re, 0);
    chk("p4_pending_popped", pops, acc0);
    nxt = ram_address;
    chk("p4_next_addr", nxt, 25'(acc0 - 32));
    enable = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == acc0; i++) @(negedge clk50);
    chk("p4_resume_acc", acc_cnt, acc0 + 1);
    chk("p4_resume_addr", last_addr, nxt[15:0]);

    // Reset while a read is in flight, late data after release
    for (int i = 0; i < 50 && cnt == 0; i++) @(negedge clk50);
    chk("p5_in_flight", cnt > 0, 1);
    model_on  = 1'b0;
    reset_n   = 1'b0;
    fill_done = 1'b0;
    sb.delete();
    @(negedge clk50);
    reset_n = 1'b1;
    @(negedge clk50);
    ram_rdata       = 16'h1234;
    ram_rdata_valid = 1'b1;
    @(negedge clk50);
    ram_rdata_valid = 1'b0;
    #3;
    chk("p5_out_valid", out_valid, 0);
    chk("p5_fill_half", fill_half, 0);
    chk("p5_ram_re", ram_re, 0);
    chk("p5_ram_address", ram_address, 0);
    chk("p5_out_data", out_data, 0);
    cycles(5);
    #3;
    chk("p5_out_valid_late", out_valid, 0);
    chk("p5_half_done", half_done, 0);
    chk("p5_underrun", underrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=1 exp=0");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $finish;
  end

endmodule
